dcpu_bus_ctrl: RTL and testbench

//  Downstream of the dcpu core. Terminates its single-master memory bus (cs/we/addr/dat/ack).

---
 rtl/dcpu_bus_ctrl_if.sv | 51 +++++
 rtl/dcpu_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dcpu_bus_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcpu_bus_ctrl_if.sv
// dcpu memory bus bundle: core side, block RAM side, IO strobe/ack side
// and the sticky error flag. The controller uses the slave modport; the
// core/environment side uses master.
interface dcpu_bus_ctrl_if #(
  parameter int RAM_AW = 12
);
  logic [15:0]       i_cpu_addr;
  logic [15:0]       i_cpu_dat;
  logic              i_cpu_we;
  logic              i_cpu_cs;
  logic              o_cpu_ack;
  logic [15:0]       o_cpu_dat;

  logic              o_ram_en;
  logic              o_ram_we;
  logic [RAM_AW-1:0] o_ram_addr;
  logic [15:0]       o_ram_dat;
  logic [15:0]       i_ram_dat;

  logic              o_io_stb;
  logic              o_io_we;
  logic [7:0]        o_io_addr;
  logic [15:0]       o_io_dat;
  logic              i_io_ack;
  logic [15:0]       i_io_dat;

  logic              o_bus_err;
  logic              i_err_clr;

  modport slave (
    input  i_cpu_addr, i_cpu_dat, i_cpu_we, i_cpu_cs,
    output o_cpu_ack, o_cpu_dat,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_dat,
    input  i_ram_dat,
    output o_io_stb, o_io_we, o_io_addr, o_io_dat,
    input  i_io_ack, i_io_dat,
    output o_bus_err,
    input  i_err_clr
  );

  modport master (
    output i_cpu_addr, i_cpu_dat, i_cpu_we, i_cpu_cs,
    input  o_cpu_ack, o_cpu_dat,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_dat,
    output i_ram_dat,
    input  o_io_stb, o_io_we, o_io_addr, o_io_dat,
    output i_io_ack, i_io_dat,
    input  o_bus_err,
    output i_err_clr
  );
endinterface

// File: rtl/dcpu_bus_ctrl.sv
// dcpu bus controller: decodes core accesses to block RAM or the IO port,
// returns ack/read data, and times out IO accesses that never complete.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for cs; RAM access issued combinationally from here
// ST_RAM_ACK | RAM data returning this cycle; ack if cs still high
// ST_IO_REQ  | o_io_stb high, waiting for i_io_ack or timeout
// ST_IO_DONE | IO finished; ack with latched data if cs still high
module dcpu_bus_ctrl #(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] IO_BASE = 16'hFF00,
  parameter int          TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  dcpu_bus_ctrl_if.slave     bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RAM_ACK = 2'd1;
  localparam logic [1:0] ST_IO_REQ  = 2'd2;
  localparam logic [1:0] ST_IO_DONE = 2'd3;

  // Counter value on the last IO_REQ cycle before a forced completion.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        io_stb_q, io_stb_d;
  logic        io_we_q, io_we_d;
  logic [7:0]  io_addr_q, io_addr_d;
  logic [15:0] io_wdat_q, io_wdat_d;
  logic [15:0] io_rdat_q, io_rdat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        upd_q, upd_d;
  logic        rd_q, rd_d;
  logic [15:0] cpu_dat_q, cpu_dat_d;
  logic        bus_err_q, bus_err_d;
  logic        err_set;
  logic        cpu_ack;
  logic        is_io;
  logic        ram_sel;
  logic [7:0]  io_off;

  assign is_io   = (bus.i_cpu_addr >= IO_BASE);
  // Only the low byte of the IO offset is used, so subtract modulo 256.
  assign io_off  = bus.i_cpu_addr[7:0] - IO_BASE[7:0];
  assign ram_sel = (state_q == ST_IDLE) && bus.i_cpu_cs && !is_io && !i_reset;

  // RAM port is driven straight from the core in IDLE so a write commits at this edge.
  always_comb begin
    bus.o_ram_en   = ram_sel;
    bus.o_ram_we   = ram_sel && bus.i_cpu_we;
    bus.o_ram_addr = i_reset ? '0 : bus.i_cpu_addr[RAM_AW-1:0];
    bus.o_ram_dat  = i_reset ? '0 : bus.i_cpu_dat;
  end

  // Ack and read-data return; o_cpu_dat only changes on an acked completion.
  always_comb begin
    cpu_ack   = bus.i_cpu_cs && ((state_q == ST_RAM_ACK) || (state_q == ST_IO_DONE));
    cpu_dat_d = cpu_dat_q;
    if (cpu_ack) begin
      if (state_q == ST_RAM_ACK) begin
        if (rd_q) cpu_dat_d = bus.i_ram_dat;
      end else if (upd_q) begin
        cpu_dat_d = io_rdat_q;
      end
    end
  end

  // Next-state and IO handshake logic.
  always_comb begin
    state_d   = state_q;
    io_stb_d  = io_stb_q;
    io_we_d   = io_we_q;
    io_addr_d = io_addr_q;
    io_wdat_d = io_wdat_q;
    io_rdat_d = io_rdat_q;
    cnt_d     = cnt_q;
    upd_d     = upd_q;
    rd_d      = rd_q;
    err_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cpu_cs) begin
          if (is_io) begin
            io_stb_d  = 1'b1;
            io_we_d   = bus.i_cpu_we;
            io_addr_d = io_off;
            io_wdat_d = bus.i_cpu_dat;
            cnt_d     = 8'd0;
            state_d   = ST_IO_REQ;
          end else begin
            rd_d      = !bus.i_cpu_we;
            state_d   = ST_RAM_ACK;
          end
        end
      end
      ST_RAM_ACK: state_d = ST_IDLE;
      ST_IO_REQ: begin
        if (bus.i_io_ack) begin
          io_stb_d  = 1'b0;
          io_rdat_d = bus.i_io_dat;
          upd_d     = !io_we_q;
          state_d   = ST_IO_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Dead device: complete with all-ones and flag it.
          io_stb_d  = 1'b0;
          io_rdat_d = 16'hFFFF;
          upd_d     = 1'b1;
          err_set   = 1'b1;
          state_d   = ST_IO_DONE;
        end else begin
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: a new timeout beats a clear in the same cycle.
  always_comb begin
    bus_err_d = bus_err_q;
    if (err_set)            bus_err_d = 1'b1;
    else if (bus.i_err_clr) bus_err_d = 1'b0;
  end

  // State registers; reset abandons any access in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      io_stb_q  <= 1'b0;
      io_we_q   <= 1'b0;
      io_addr_q <= 8'd0;
      io_wdat_q <= 16'd0;
      io_rdat_q <= 16'd0;
      cnt_q     <= 8'd0;
      upd_q     <= 1'b0;
      rd_q      <= 1'b0;
      cpu_dat_q <= 16'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      io_stb_q  <= io_stb_d;
      io_we_q   <= io_we_d;
      io_addr_q <= io_addr_d;
      io_wdat_q <= io_wdat_d;
      io_rdat_q <= io_rdat_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
      rd_q      <= rd_d;
      cpu_dat_q <= cpu_dat_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.o_cpu_ack = cpu_ack;
  assign bus.o_cpu_dat = cpu_dat_d;
  assign bus.o_io_stb  = io_stb_q;
  assign bus.o_io_we   = io_we_q;
  assign bus.o_io_addr = io_addr_q;
  assign bus.o_io_dat  = io_wdat_q;
  assign bus.o_bus_err = bus_err_q;

endmodule

// File: tb/tb_dcpu_bus_ctrl.sv
// Bench for dcpu_bus_ctrl: directed scenarios plus randomized accesses,
// each checked against a transaction-level model of latency, data and error.
module tb_dcpu_bus_ctrl;
  localparam int          RAM_AW  = 12;
  localparam logic [15:0] IO_BASE = 16'hFF00;
  localparam int          TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  logic [15:0] ref_mem [0:4095];
  logic [15:0] exp_cpu_dat;
  logic        exp_err;

  logic [15:0] ram_mem [0:4095];
  logic [15:0] ram_q;

  dcpu_bus_ctrl_if #(.RAM_AW(RAM_AW)) bus();

  dcpu_bus_ctrl #(.RAM_AW(RAM_AW), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous block RAM attached to the controller.
  always @(posedge clk) begin
    if (bus.o_ram_en) begin
      if (bus.o_ram_we) ram_mem[bus.o_ram_addr] <= bus.o_ram_dat;
      ram_q <= ram_mem[bus.o_ram_addr];
    end
  end
  assign bus.i_ram_dat = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic err_step(input bit set, input bit clr);
    if (set)      exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
  endtask

  // Idle cycles with cs low; clr_mode 0=never, 1=random, 2=always.
  task automatic idle(input int n, input int clr_mode);
    bit clr;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.i_cpu_cs   = 1'b0;
      bus.i_cpu_addr = 16'($urandom);
      bus.i_cpu_we   = 1'($urandom);
      bus.i_cpu_dat  = 16'($urandom);
      bus.i_io_ack   = 1'b0;
      clr = (clr_mode == 2) || (clr_mode == 1 && $urandom_range(0, 3) == 0);
      bus.i_err_clr  = clr;
      @(negedge clk);
      chk("idle_ack", 32'(bus.o_cpu_ack), 32'(0));
      chk("idle_dat", 32'(bus.o_cpu_dat), 32'(exp_cpu_dat));
      chk("idle_stb", 32'(bus.o_io_stb), 32'(0));
      chk("err", 32'(bus.o_bus_err), 32'(exp_err));
      err_step(1'b0, clr);
    end
  endtask

  // One core access. io_delay = IO_REQ cycle in which the device acks (0 = never).
  // drop_at = first cycle with cs low (0 = cs held throughout).
  task automatic txn(input logic [15:0] addr, input logic we, input logic [15:0] wdat,
                     input int io_delay, input logic [15:0] io_rdata,
                     input int drop_at, input bit clr_hold);
    bit          is_io, tmo, kept, clr;
    int          stb_len, lat, stbcnt, stb_n, en_n, ack_n, ack_c;
    logic [15:0] exp_dat, ack_dat;
    is_io  = (addr >= IO_BASE);
    stbcnt = 0; stb_n = 0; en_n = 0; ack_n = 0; ack_c = 0; ack_dat = 16'd0;
    if (is_io) begin
      tmo     = !(io_delay >= 1 && io_delay <= TIMEOUT);
      stb_len = tmo ? TIMEOUT : io_delay;
      lat     = stb_len + 2;
      exp_dat = tmo ? 16'hFFFF : (we ? exp_cpu_dat : io_rdata);
    end else begin
      tmo     = 1'b0;
      stb_len = 0;
      lat     = 2;
      exp_dat = we ? exp_cpu_dat : ref_mem[int'(addr) % 4096];
      if (we) ref_mem[int'(addr) % 4096] = wdat;
    end
    kept = (drop_at == 0) || (drop_at > lat);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.i_cpu_cs   = 1'b1;
        bus.i_cpu_addr = addr;
        bus.i_cpu_we   = we;
        bus.i_cpu_dat  = wdat;
      end else begin
        bus.i_cpu_cs   = !(drop_at > 0 && c >= drop_at);
        bus.i_cpu_addr = 16'($urandom);
        bus.i_cpu_we   = 1'($urandom);
        bus.i_cpu_dat  = 16'($urandom);
      end
      clr = clr_hold || ($urandom_range(0, 3) == 0);
      bus.i_err_clr = clr;
      if (bus.o_io_stb) begin
        stbcnt++;
        bus.i_io_ack = (stbcnt == io_delay);
        bus.i_io_dat = bus.i_io_ack ? io_rdata : 16'($urandom);
      end else begin
        bus.i_io_ack = 1'b0;
      end
      @(negedge clk);
      if (bus.o_cpu_ack) begin
        ack_n++;
        ack_c   = c;
        ack_dat = bus.o_cpu_dat;
      end
      if (bus.o_io_stb) begin
        stb_n++;
        if (stb_n == 1) begin
          chk("io_addr", 32'(bus.o_io_addr), 32'(addr - IO_BASE));
          chk("io_we", 32'(bus.o_io_we), 32'(we));
          chk("io_dat", 32'(bus.o_io_dat), 32'(wdat));
        end
      end
      if (bus.o_ram_en) begin
        en_n++;
        if (en_n == 1) begin
          chk("ram_addr", 32'(bus.o_ram_addr), 32'(int'(addr) % 4096));
          chk("ram_we", 32'(bus.o_ram_we), 32'(we));
          if (we) chk("ram_dat", 32'(bus.o_ram_dat), 32'(wdat));
        end
      end
      chk("err", 32'(bus.o_bus_err), 32'(exp_err));
      err_step(tmo && (c == stb_len + 1), clr);
    end
    chk("ram_en_cnt", en_n, is_io ? 0 : 1);
    chk("stb_cycles", stb_n, stb_len);
    if (kept) begin
      chk("ack_cnt", ack_n, 1);
      chk("ack_cycle", ack_c, lat);
      chk("ack_dat", 32'(ack_dat), 32'(exp_dat));
      exp_cpu_dat = exp_dat;
    end else begin
      chk("abort_ack", ack_n, 0);
    end
  endtask

  initial begin
    bus.i_cpu_cs   = 1'b0;
    bus.i_cpu_addr = 16'd0;
    bus.i_cpu_we   = 1'b0;
    bus.i_cpu_dat  = 16'd0;
    bus.i_io_ack   = 1'b0;
    bus.i_io_dat   = 16'd0;
    bus.i_err_clr  = 1'b0;
    exp_cpu_dat    = 16'd0;
    exp_err        = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'd0;

    // Reset values, and RAM port gated while reset is high.
    rst = 1'b1;
    #2;
    bus.i_cpu_cs   = 1'b1;
    bus.i_cpu_addr = 16'h0005;
    bus.i_cpu_we   = 1'b1;
    bus.i_cpu_dat  = 16'h5A5A;
    #1;
    chk("rst_ack", 32'(bus.o_cpu_ack), 32'(0));
    chk("rst_dat", 32'(bus.o_cpu_dat), 32'(0));
    chk("rst_stb", 32'(bus.o_io_stb), 32'(0));
    chk("rst_err", 32'(bus.o_bus_err), 32'(0));
    chk("rst_ram_en", 32'(bus.o_ram_en), 32'(0));
    chk("rst_ram_we", 32'(bus.o_ram_we), 32'(0));
    chk("rst_ram_dat", 32'(bus.o_ram_dat), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.i_cpu_cs = 1'b0;
    idle(1, 0);

    // Preload a block of RAM through the controller.
    for (int a = 0; a < 16; a++) begin
      txn(16'(a), 1'b1, 16'($urandom), 0, 16'd0, 0, 1'b0);
      idle(1, 1);
    end
    txn(16'h0010, 1'b1, 16'h1234, 0, 16'd0, 0, 1'b0);
    idle(1, 1);
    txn(16'h0010, 1'b0, 16'h0000, 0, 16'd0, 0, 1'b0);
    idle(2, 1);

    // Back-to-back write then read of the same word.
    txn(16'h0020, 1'b1, 16'hBEEF, 0, 16'd0, 0, 1'b0);
    txn(16'h0020, 1'b0, 16'h0000, 0, 16'd0, 0, 1'b0);
    idle(1, 1);

    // IO write acked in the 3rd IO_REQ cycle; IO read acked in the 1st.
    txn(16'hFF05, 1'b1, 16'h00AA, 3, 16'h0000, 0, 1'b0);
    idle(1, 1);
    txn(16'hFFFE, 1'b0, 16'h0000, 1, 16'hC0DE, 0, 1'b0);
    idle(1, 1);

    // Dead IO read: timeout, all-ones data, sticky error until cleared.
    txn(16'hFF10, 1'b0, 16'h0000, 0, 16'h5555, 0, 1'b0);
    idle(3, 0);
    idle(1, 2);
    idle(1, 0);

    // Ack on the timeout cycle wins; then a timeout beats a held clear.
    txn(16'hFF11, 1'b0, 16'h0000, TIMEOUT, 16'h1357, 0, 1'b1);
    txn(16'hFF12, 1'b0, 16'h0000, 0, 16'h0000, 0, 1'b1);
    idle(2, 0);
    idle(1, 2);

    // cs dropped during IO_REQ: handshake completes, no ack; next RAM read normal.
    txn(16'hFF20, 1'b0, 16'h0000, 5, 16'h2468, 3, 1'b0);
    txn(16'h0020, 1'b0, 16'h0000, 0, 16'd0, 0, 1'b0);
    idle(1, 1);
    // cs dropped in RAM_ACK of a write: no ack, write still lands.
    txn(16'h0030, 1'b1, 16'h7777, 0, 16'd0, 2, 1'b0);
    idle(1, 1);
    txn(16'h0030, 1'b0, 16'h0000, 0, 16'd0, 0, 1'b0);
    idle(1, 1);

    // Reset asserted mid IO_REQ.
    @(posedge clk); #1;
    bus.i_cpu_cs   = 1'b1;
    bus.i_cpu_addr = 16'hFF30;
    bus.i_cpu_we   = 1'b0;
    bus.i_io_ack   = 1'b0;
    bus.i_err_clr  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_stb", 32'(bus.o_io_stb), 32'(1));
    #1 rst = 1'b1;
    bus.i_cpu_addr = 16'h0005;
    #1;
    chk("async_rst_stb", 32'(bus.o_io_stb), 32'(0));
    chk("async_rst_ack", 32'(bus.o_cpu_ack), 32'(0));
    chk("async_rst_ram_en", 32'(bus.o_ram_en), 32'(0));
    exp_err     = 1'b0;
    exp_cpu_dat = 16'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.i_cpu_cs = 1'b0;
    idle(3, 1);
    txn(16'h0020, 1'b0, 16'h0000, 0, 16'd0, 0, 1'b0);
    idle(1, 1);

    // Randomized mix of RAM and IO accesses.
    for (int t = 0; t < 80; t++) begin
      bit          io;
      logic        we;
      logic [15:0] addr;
      int          dly, drop;
      io   = 1'($urandom);
      we   = 1'($urandom);
      if (io) addr = IO_BASE + 16'($urandom_range(0, 255));
      else    addr = 16'($urandom_range(0, 15) * 4096 + $urandom_range(0, 15));
      dly  = $urandom_range(0, TIMEOUT + 2);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(2, io ? TIMEOUT + 2 : 2) : 0;
      txn(addr, we, 16'($urandom), dly, 16'($urandom), drop, 1'b0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2), 1);
    end
    idle(2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
